// File: rtl/dff_pkg.sv
// Shared constants for the dual-reset register family.
// Selects the implementation style and the default reset value.
package dff_pkg;

    localparam int   IMPL_BEHAV  = 0;
    localparam int   IMPL_STRUCT = 1;

    localparam logic RST_VAL_DEF = 1'b0;

endpackage

// File: rtl/dff_struct_bit.sv
// One-bit master-slave edge-triggered cell.
// Async reset forces both latches directly; sync reset is folded into d_eff upstream.
module dff_struct_bit
    import dff_pkg::*;
#(
    parameter logic RST_BIT = RST_VAL_DEF
) (
    input  logic clk,
    input  logic rst_async,
    input  logic d_eff,
    output logic q
);

    logic m;
    logic clk_n;

    not u_clk_inv (clk_n, clk);

    // Master: open while clk is low, so it holds the value present at the rising edge.
    always_latch begin
        if (rst_async)
            m <= RST_BIT;
        else if (clk_n)
            m <= d_eff;
    end

    // Slave: open while clk is high, presenting the captured master value.
    always_latch begin
        if (rst_async)
            q <= RST_BIT;
        else if (clk)
            q <= m;
    end

endmodule

// File: rtl/dff_dual_rst.sv
// WIDTH-bit register with async and sync reset.
// IMPL picks a behavioural flop or the structural master-slave cell array.
module dff_dual_rst
    import dff_pkg::*;
#(
    parameter int               WIDTH   = 1,
    parameter int               IMPL    = IMPL_BEHAV,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{RST_VAL_DEF}}
) (
    input  logic             clk,
    input  logic             rst_async,
    input  logic             rst_sync,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    if (IMPL == IMPL_STRUCT) begin : g_struct

        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            logic d_eff;

            // Sync reset steers the data path to this bit's reset value.
            if (RST_VAL[i]) begin : g_one
                or u_or (d_eff, D[i], rst_sync);
            end else begin : g_zero
                logic rs_n;
                not u_not (rs_n, rst_sync);
                and u_and (d_eff, D[i], rs_n);
            end

            dff_struct_bit #(
                .RST_BIT (RST_VAL[i])
            ) u_bit (
                .clk       (clk),
                .rst_async (rst_async),
                .d_eff     (d_eff),
                .q         (Q[i])
            );
        end

    end else begin : g_behav

        always_ff @(posedge clk or posedge rst_async) begin
            if (rst_async)
                Q <= RST_VAL;
            else if (rst_sync)
                Q <= RST_VAL;
            else
                Q <= D;
        end

    end

endmodule

// File: tb/tb_dff_dual_rst.sv
// Directed and randomised checks of both implementations side by side.
// Covers WIDTH=1/RST_VAL=0 timeline and WIDTH=8/RST_VAL=A5 random run.
module tb_dff_dual_rst;
    import dff_pkg::*;

    logic       clk = 1'b0;
    logic       ra1, rs1, d1;
    logic       qb1, qs1;
    logic       ra8, rs8;
    logic [7:0] d8, qb8, qs8, m8;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dff_dual_rst #(.WIDTH(1), .IMPL(IMPL_BEHAV), .RST_VAL(1'b0)) u_b1 (
        .clk(clk), .rst_async(ra1), .rst_sync(rs1), .D(d1), .Q(qb1)
    );
    dff_dual_rst #(.WIDTH(1), .IMPL(IMPL_STRUCT), .RST_VAL(1'b0)) u_s1 (
        .clk(clk), .rst_async(ra1), .rst_sync(rs1), .D(d1), .Q(qs1)
    );
    dff_dual_rst #(.WIDTH(8), .IMPL(IMPL_BEHAV), .RST_VAL(8'hA5)) u_b8 (
        .clk(clk), .rst_async(ra8), .rst_sync(rs8), .D(d8), .Q(qb8)
    );
    dff_dual_rst #(.WIDTH(8), .IMPL(IMPL_STRUCT), .RST_VAL(8'hA5)) u_s8 (
        .clk(clk), .rst_async(ra8), .rst_sync(rs8), .D(d8), .Q(qs8)
    );

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h want %h", tag, $time, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic exp);
        chk({tag, "_b"}, {7'd0, qb1}, {7'd0, exp});
        chk({tag, "_s"}, {7'd0, qs1}, {7'd0, exp});
    endtask

    task automatic chk8(input string tag, input logic [7:0] exp);
        chk({tag, "_b"}, qb8, exp);
        chk({tag, "_s"}, qs8, exp);
    endtask

    initial begin
        ra1 = 1'b1; rs1 = 1'b0; d1 = 1'b0;
        ra8 = 1'b1; rs8 = 1'b0; d8 = 8'h00;
        m8  = 8'hA5;

        #1   chk1("rst_t1",    1'b0);
        #5   chk1("rst_t6",    1'b0);
        #10  chk1("rst_t16",   1'b0);
        #4   ra1 = 1'b0; d1 = 1'b1;
        #1   chk1("rel_t21",   1'b0);
        #6   chk1("load_t27",  1'b1);
        #13  rs1 = 1'b1;
        #1   chk1("srs_t41",   1'b1);
        #6   chk1("srs_t47",   1'b0);
        #10  chk1("srs_t57",   1'b0);
        #3   rs1 = 1'b0; d1 = 1'b0;
        #7   chk1("d0_t67",    1'b0);
        #13  d1 = 1'b1;
        #2   chk1("hold_t82",  1'b0);
        #5   chk1("d1_t87",    1'b1);
        #13  ra1 = 1'b1;
        #1   chk1("ars_t101",  1'b0);
        #15  chk1("ars_t116",  1'b0);
        #4   ra1 = 1'b0;
        #1   chk1("rel_t121",  1'b0);
        #6   chk1("load_t127", 1'b1);

        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            d8  = 8'($urandom);
            rs8 = ($urandom_range(0, 3) == 0);
            ra8 = ($urandom_range(0, 7) == 0);
            #1;
            if (ra8) m8 = 8'hA5;
            chk8("rnd_mid", m8);
            @(posedge clk);
            #1;
            m8 = (ra8 || rs8) ? 8'hA5 : d8;
            chk8("rnd_edge", m8);
        end

        @(negedge clk);
        ra8 = 1'b0; rs8 = 1'b0; d8 = 8'h3C;
        @(posedge clk);
        #1 chk8("w8_3c", 8'h3C);
        @(negedge clk);
        rs8 = 1'b1; d8 = 8'hFF;
        #1 chk8("w8_srs_mid", 8'h3C);
        @(posedge clk);
        #1 chk8("w8_srs_ff", 8'hA5);
        @(negedge clk);
        rs8 = 1'b0;
        @(posedge clk);
        #1 chk8("w8_ff", 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
